// File: rtl/axi_burst_to_lite.sv
// axi_burst_to_lite
//   Converts AXI4 bursts into sequences of single-beat AXI-Lite transactions.
//   The read and write paths are independent and each serves one burst at a time.
//
//   Compile-time option: BURST_WRAP_EN. When it is defined, WRAP bursts wrap
//   at the (len+1)<<size boundary. When it is undefined, WRAP is treated as
//   INCR and no wrap logic is built.
//
// Ports
//   aclk, aresetn         clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*       AXI4 write slave port (ID_W-bit ids)
//   s_axi_ar*/r*          AXI4 read slave port
//   m_axi_aw*/w*/b*       AXI-Lite write master port
//   m_axi_ar*/r*          AXI-Lite read master port
module axi_burst_to_lite #(
  parameter int ID_W = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] s_axi_awid,
  input  logic [31:0]     s_axi_awaddr,
  input  logic [7:0]      s_axi_awlen,
  input  logic [2:0]      s_axi_awsize,
  input  logic [1:0]      s_axi_awburst,
  input  logic [2:0]      s_axi_awprot,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [31:0]     s_axi_wdata,
  input  logic [3:0]      s_axi_wstrb,
  input  logic            s_axi_wlast,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [ID_W-1:0] s_axi_bid,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready,
  input  logic [ID_W-1:0] s_axi_arid,
  input  logic [31:0]     s_axi_araddr,
  input  logic [7:0]      s_axi_arlen,
  input  logic [2:0]      s_axi_arsize,
  input  logic [1:0]      s_axi_arburst,
  input  logic [2:0]      s_axi_arprot,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [ID_W-1:0] s_axi_rid,
  output logic [31:0]     s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rlast,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready,
  output logic [31:0]     m_axi_awaddr,
  output logic [2:0]      m_axi_awprot,
  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  output logic [31:0]     m_axi_wdata,
  output logic [3:0]      m_axi_wstrb,
  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  input  logic [1:0]      m_axi_bresp,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,
  output logic [31:0]     m_axi_araddr,
  output logic [2:0]      m_axi_arprot,
  output logic            m_axi_arvalid,
  input  logic            m_axi_arready,
  input  logic [31:0]     m_axi_rdata,
  input  logic [1:0]      m_axi_rresp,
  input  logic            m_axi_rvalid,
  output logic            m_axi_rready
);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ADDR  = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  localparam logic [2:0] W_IDLE  = 3'd0;
  localparam logic [2:0] W_DATA  = 3'd1;
  localparam logic [2:0] W_ISSUE = 3'd2;
  localparam logic [2:0] W_RESP  = 3'd3;
  localparam logic [2:0] W_B     = 3'd4;

  // Beat-to-beat address step. FIXED holds, reserved behaves as INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [7:0] len);
    logic [31:0] step;
`ifdef BURST_WRAP_EN
    logic [31:0] mask;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
`else
    logic [7:0] unused_len;
    unused_len = len;
`endif
    step = 32'd1 << size;
    next_addr = addr + step;
    if (burst == 2'b00) next_addr = addr;
`ifdef BURST_WRAP_EN
    if (burst == 2'b10) next_addr = (addr & ~mask) | ((addr + step) & mask);
`endif
  endfunction

  logic            unused_wlast;
  assign unused_wlast = s_axi_wlast;

  // ---------------- read path ----------------
  logic [1:0]      r_state;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_addr;
  logic [7:0]      r_len, r_cnt;
  logic [2:0]      r_size, r_prot;
  logic [1:0]      r_burst;

  assign s_axi_arready = (r_state == R_IDLE);
  assign m_axi_arvalid = (r_state == R_ADDR);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arprot  = r_prot;
  assign s_axi_rvalid  = (r_state == R_DATA) && m_axi_rvalid;
  assign m_axi_rready  = (r_state == R_DATA) && s_axi_rready;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rid     = r_id;
  assign s_axi_rlast   = (r_cnt == r_len);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_prot  <= '0;
      r_burst <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (s_axi_arvalid) begin
          r_id    <= s_axi_arid;
          r_addr  <= s_axi_araddr;
          r_len   <= s_axi_arlen;
          r_size  <= s_axi_arsize;
          r_burst <= s_axi_arburst;
          r_prot  <= s_axi_arprot;
          r_cnt   <= '0;
          r_state <= R_ADDR;
        end
        R_ADDR: if (m_axi_arready) r_state <= R_DATA;
        R_DATA: if (m_axi_rvalid && s_axi_rready) begin
          if (r_cnt == r_len) begin
            r_state <= R_IDLE;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
            r_addr  <= next_addr(r_addr, r_size, r_burst, r_len);
            r_state <= R_ADDR;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write path ----------------
  logic [2:0]      w_state;
  logic [ID_W-1:0] w_id;
  logic [31:0]     w_addr, w_data_q;
  logic [3:0]      w_strb_q;
  logic [7:0]      w_len, w_cnt;
  logic [2:0]      w_size, w_prot;
  logic [1:0]      w_burst, b_acc;
  logic            aw_done, wd_done;
  logic            aw_fire, wd_fire;

  assign s_axi_awready = (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  // AW and W rise together; each drops on its own handshake.
  assign m_axi_awvalid = (w_state == W_ISSUE) && !aw_done;
  assign m_axi_wvalid  = (w_state == W_ISSUE) && !wd_done;
  assign m_axi_awaddr  = w_addr;
  assign m_axi_awprot  = w_prot;
  assign m_axi_wdata   = w_data_q;
  assign m_axi_wstrb   = w_strb_q;
  assign m_axi_bready  = (w_state == W_RESP);
  assign s_axi_bvalid  = (w_state == W_B);
  assign s_axi_bid     = w_id;
  assign s_axi_bresp   = b_acc;
  assign aw_fire       = m_axi_awvalid && m_axi_awready;
  assign wd_fire       = m_axi_wvalid && m_axi_wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      w_id     <= '0;
      w_addr   <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_size   <= '0;
      w_prot   <= '0;
      w_burst  <= '0;
      b_acc    <= '0;
      aw_done  <= 1'b0;
      wd_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axi_awvalid) begin
          w_id    <= s_axi_awid;
          w_addr  <= s_axi_awaddr;
          w_len   <= s_axi_awlen;
          w_size  <= s_axi_awsize;
          w_burst <= s_axi_awburst;
          w_prot  <= s_axi_awprot;
          w_cnt   <= '0;
          w_state <= W_DATA;
        end
        W_DATA: if (s_axi_wvalid) begin
          w_data_q <= s_axi_wdata;
          w_strb_q <= s_axi_wstrb;
          aw_done  <= 1'b0;
          wd_done  <= 1'b0;
          w_state  <= W_ISSUE;
        end
        W_ISSUE: begin
          if (aw_fire) aw_done <= 1'b1;
          if (wd_fire) wd_done <= 1'b1;
          if ((aw_done || aw_fire) && (wd_done || wd_fire)) w_state <= W_RESP;
        end
        W_RESP: if (m_axi_bvalid) begin
          // Worst response across the burst is reported once at the end.
          if (m_axi_bresp > b_acc) b_acc <= m_axi_bresp;
          if (w_cnt == w_len) begin
            w_state <= W_B;
          end else begin
            w_cnt   <= w_cnt + 8'd1;
            w_addr  <= next_addr(w_addr, w_size, w_burst, w_len);
            w_state <= W_DATA;
          end
        end
        W_B: if (s_axi_bready) begin
          b_acc   <= 2'b00;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_to_lite.sv
module tb_axi_burst_to_lite;
  localparam int ID_W = 4;
  localparam int TMO  = 300;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [ID_W-1:0] s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0, s_axi_wdata = '0, s_axi_rdata;
  logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0]  s_axi_awsize = '0, s_axi_arsize = '0, s_axi_awprot = '0, s_axi_arprot = '0;
  logic [1:0]  s_axi_awburst = '0, s_axi_arburst = '0, s_axi_bresp, s_axi_rresp;
  logic [3:0]  s_axi_wstrb = '0;
  logic s_axi_awvalid = 0, s_axi_awready, s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready = 0;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata = '0;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic m_axi_awvalid, m_axi_awready = 0, m_axi_wvalid, m_axi_wready = 0;
  logic m_axi_bvalid = 0, m_axi_bready, m_axi_arvalid, m_axi_arready = 0;
  logic m_axi_rvalid = 0, m_axi_rready;

  axi_burst_to_lite #(.ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------- reference model ----------
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int unsigned i,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input logic [7:0] len);
    logic [31:0] step, bnd, base;
    step = 32'd1 << size;
    bnd  = (32'(len) + 32'd1) * step;
    base = a - (a % bnd);
    if (burst == 2'b00) return a;
`ifdef BURST_WRAP_EN
    if (burst == 2'b10) return base + (((a - base) + i * step) % bnd);
`endif
    return a + i * step;
  endfunction

  // Lite peripheral contents as a function of address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h1faf_f000) return 32'h0123_4567;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [1:0] rresp_fn(input logic [31:0] a);
    return (a[9:8] == 2'b11) ? 2'b10 : 2'b00;
  endfunction

  logic [34:0] obs_ar_q[$];   // {prot, addr}
  logic [34:0] obs_aw_q[$];   // {prot, addr}
  logic [35:0] obs_w_q[$];    // {strb, data}
  logic [1:0]  bresp_q[$];

  // ---------- Lite read slave ----------
  initial begin
    logic ar_hs, r_hs;
    logic [31:0] pend_q[$];
    forever begin
      @(negedge aclk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (ar_hs) begin
        obs_ar_q.push_back({m_axi_arprot, m_axi_araddr});
        pend_q.push_back(m_axi_araddr);
      end
      @(posedge aclk); #1;
      if (!aresetn) begin
        pend_q.delete();
        m_axi_rvalid = 0;
        m_axi_arready = 0;
      end else begin
        m_axi_arready = 1'($urandom_range(0, 1));
        if (r_hs) m_axi_rvalid = 0;
        if (!m_axi_rvalid && pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          m_axi_rvalid = 1;
          m_axi_rdata  = rd_fn(pend_q[0]);
          m_axi_rresp  = rresp_fn(pend_q[0]);
          void'(pend_q.pop_front());
        end
      end
    end
  end

  // ---------- Lite write slave ----------
  initial begin
    logic aw_hs, w_hs, b_hs, got_aw, got_w, prev_any;
    got_aw = 0; got_w = 0; prev_any = 0;
    forever begin
      @(negedge aclk);
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      if ((m_axi_awvalid || m_axi_wvalid) && !prev_any)
        check("aw_w_together", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
      prev_any = m_axi_awvalid || m_axi_wvalid;
      if (aw_hs) begin got_aw = 1; obs_aw_q.push_back({m_axi_awprot, m_axi_awaddr}); end
      if (w_hs)  begin got_w = 1;  obs_w_q.push_back({m_axi_wstrb, m_axi_wdata}); end
      @(posedge aclk); #1;
      if (!aresetn) begin
        got_aw = 0; got_w = 0;
        bresp_q.delete();
        m_axi_bvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
      end else begin
        m_axi_awready = 1'($urandom_range(0, 1));
        m_axi_wready  = 1'($urandom_range(0, 1));
        if (b_hs) m_axi_bvalid = 0;
        if (got_aw && got_w && !m_axi_bvalid && $urandom_range(0, 2) != 0) begin
          m_axi_bvalid = 1;
          m_axi_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
          got_aw = 0; got_w = 0;
        end
      end
    end
  end

  // ---------- AXI4 master side ----------
  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot,
                         input int stall_beat);
    int t, beat, held;
    logic [31:0] ea;
    obs_ar_q.delete();
    @(posedge aclk); #1;
    s_axi_arvalid = 1; s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arprot = prot;
    t = 0;
    do begin @(negedge aclk); t++; end while (!s_axi_arready && t < TMO);
    check("ar_accept", s_axi_arready, 1);
    @(posedge aclk); #1;
    s_axi_arvalid = 0;
    beat = 0; held = 0; t = 0;
    while (beat <= int'(len) && t < TMO * 4) begin
      @(posedge aclk); #1;
      if (beat == stall_beat && held < 5) begin s_axi_rready = 0; held++; end
      else s_axi_rready = ($urandom_range(0, 3) != 0);
      @(negedge aclk); t++;
      if (s_axi_rvalid && s_axi_rready) begin
        ea = beat_addr(a, beat, size, burst, len);
        check("rdata", s_axi_rdata, rd_fn(ea));
        check("rresp", s_axi_rresp, rresp_fn(ea));
        check("rid", s_axi_rid, id);
        check("rlast", s_axi_rlast, (beat == int'(len)));
        beat++;
      end
    end
    check("r_beats", beat, int'(len) + 1);
    @(posedge aclk); #1;
    s_axi_rready = 0;
    check("ar_count", obs_ar_q.size(), int'(len) + 1);
    for (int i = 0; i < obs_ar_q.size() && i <= int'(len); i++)
      check("lite_araddr", obs_ar_q[i], {prot, beat_addr(a, i, size, burst, len)});
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot,
                          input int abort_at);
    int t;
    logic [35:0] exp_w[$];
    logic [1:0] exp_resp;
    exp_resp = 2'b00;
    for (int i = 0; i < bresp_q.size(); i++)
      if (bresp_q[i] > exp_resp) exp_resp = bresp_q[i];
    obs_aw_q.delete(); obs_w_q.delete();
    @(posedge aclk); #1;
    s_axi_awvalid = 1; s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awprot = prot;
    t = 0;
    do begin @(negedge aclk); t++; end while (!s_axi_awready && t < TMO);
    check("aw_accept", s_axi_awready, 1);
    @(posedge aclk); #1;
    s_axi_awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wvalid = 1;
      s_axi_wdata  = $urandom;
      s_axi_wstrb  = 4'($urandom);
      s_axi_wlast  = 1'($urandom);
      exp_w.push_back({s_axi_wstrb, s_axi_wdata});
      t = 0;
      do begin @(negedge aclk); t++; end while (!s_axi_wready && t < TMO);
      check("w_accept", s_axi_wready, 1);
      @(posedge aclk); #1;
      s_axi_wvalid = 0;
      if (i == abort_at) begin
        #1 aresetn = 0;
        #1;
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, s_axi_wready,
                             m_axi_bready, m_axi_arvalid, s_axi_rvalid, m_axi_rready}, 8'h00);
        check("rst_readies", {s_axi_awready, s_axi_arready}, 2'b11);
        repeat (2) @(posedge aclk);
        @(negedge aclk); aresetn = 1;
        @(posedge aclk); #1;
        check("rst_release_awready", s_axi_awready, 1);
        return;
      end
      repeat ($urandom_range(0, 2)) @(posedge aclk);
      #1;
    end
    t = 0;
    do begin
      @(posedge aclk); #1;
      s_axi_bready = ($urandom_range(0, 3) != 0);
      @(negedge aclk); t++;
    end while (!(s_axi_bvalid && s_axi_bready) && t < TMO);
    check("b_handshake", s_axi_bvalid && s_axi_bready, 1);
    check("bid", s_axi_bid, id);
    check("bresp", s_axi_bresp, exp_resp);
    @(posedge aclk); #1;
    s_axi_bready = 0;
    repeat (3) @(negedge aclk);
    check("b_single", s_axi_bvalid, 0);
    check("aw_count", obs_aw_q.size(), int'(len) + 1);
    check("w_count", obs_w_q.size(), int'(len) + 1);
    for (int i = 0; i < obs_aw_q.size() && i <= int'(len); i++)
      check("lite_awaddr", obs_aw_q[i], {prot, beat_addr(a, i, size, burst, len)});
    for (int i = 0; i < obs_w_q.size() && i <= int'(len); i++)
      check("lite_wdata", obs_w_q[i], exp_w[i]);
  endtask

  task automatic gen_burst(output logic [31:0] a, output logic [7:0] len,
                           output logic [2:0] size, output logic [1:0] burst);
    int unsigned k;
    size  = 3'($urandom_range(0, 2));
    burst = 2'($urandom_range(0, 3));
    k     = $urandom_range(0, 3);
    if (burst == 2'b10) len = 8'((2 << k) - 1);
    else len = 8'($urandom_range(0, 7));
    a = $urandom;
    if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
    a = a & ~((32'd1 << size) - 32'd1);
  endtask

  initial begin
    logic [31:0] ra, wa;
    logic [7:0]  rl, wl;
    logic [2:0]  rs, ws, rp, wp;
    logic [1:0]  rb, wb;
    logic [ID_W-1:0] rid, wid;

    repeat (3) @(negedge aclk);
    check("rst_outs", {m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, s_axi_wready,
                       m_axi_bready, m_axi_arvalid, s_axi_rvalid, m_axi_rready}, 8'h00);
    check("rst_readies", {s_axi_awready, s_axi_arready}, 2'b11);
    aresetn = 1;
    repeat (2) @(posedge aclk);

    do_read(4'd5, 32'h1faf_f000, 8'd0, 3'd2, 2'b01, 3'd0, -1);

    bresp_q = '{2'b00, 2'b00, 2'b00, 2'b00};
    do_write(4'd2, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 3'd0, -1);

    do_read(4'd7, 32'h0000_0040, 8'd2, 3'd2, 2'b00, 3'd1, 1);

    bresp_q = '{2'b00, 2'b10, 2'b00, 2'b00};
    do_write(4'd9, 32'h0000_2000, 8'd3, 3'd2, 2'b01, 3'd2, -1);

    do_read(4'd3, 32'h0000_000C, 8'd3, 3'd2, 2'b10, 3'd0, -1);

    bresp_q = '{2'b00, 2'b00, 2'b00, 2'b00};
    do_write(4'd4, 32'h0000_3000, 8'd3, 3'd2, 2'b01, 3'd0, 1);
    bresp_q = '{2'b00, 2'b01, 2'b00};
    do_write(4'd6, 32'h0000_3100, 8'd2, 3'd2, 2'b01, 3'd0, -1);

    for (int n = 0; n < 25; n++) begin
      gen_burst(ra, rl, rs, rb);
      gen_burst(wa, wl, ws, wb);
      rid = 4'($urandom); wid = 4'($urandom);
      rp = 3'($urandom); wp = 3'($urandom);
      bresp_q.delete();
      for (int i = 0; i <= int'(wl); i++)
        bresp_q.push_back(($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00);
      fork
        do_read(rid, ra, rl, rs, rb, rp, (n % 3 == 0) ? 0 : -1);
        do_write(wid, wa, wl, ws, wb, wp, -1);
      join
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_burst_to_lite.md
# axi_burst_to_lite

Bridge that converts AXI4 burst transactions from the CPU/interconnect into sequences of single-beat AXI-Lite transactions for the SoC peripheral bus, so that the seven-segment controller and similar Lite slaves can be reached by burst-capable masters. Read and write paths are independent state machines; each serves one burst at a time. Sits directly upstream of the peripheral slaves.

## Interface
- ID_W, 4, AXI4 ID width.
- aclk  in  1  clock.
- aresetn  in  1  async active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst/awprot/awvalid  in  ID_W/32/8/3/2/3/1  AXI4 write address.
- s_axi_awready  out  1.
- s_axi_wdata/wstrb/wlast/wvalid  in  32/4/1/1  AXI4 write data.
- s_axi_wready  out  1.
- s_axi_bid/bresp/bvalid  out  ID_W/2/1; s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arsize/arburst/arprot/arvalid  in  ID_W/32/8/3/2/3/1; s_axi_arready  out  1.
- s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_W/32/2/1/1; s_axi_rready  in  1.
- m_axi_awaddr/awprot/awvalid  out  32/3/1; m_axi_awready  in  1.
- m_axi_wdata/wstrb/wvalid  out  32/4/1; m_axi_wready  in  1.
- m_axi_bresp/bvalid  in  2/1; m_axi_bready  out  1.
- m_axi_araddr/arprot/arvalid  out  32/3/1; m_axi_arready  in  1.
- m_axi_rdata/rresp/rvalid  in  32/2/1; m_axi_rready  out  1.

## Operation
- Read FSM R_IDLE → R_ADDR → R_DATA. s_axi_arready = (state==R_IDLE). On AR handshake latch id, addr, len, size, burst, prot; beat counter = 0; go R_ADDR.
- R_ADDR: m_axi_arvalid=1, m_axi_araddr = beat address; on m_axi_arready go R_DATA.
- R_DATA: combinational pass-through s_axi_rvalid=m_axi_rvalid, m_axi_rready=s_axi_rready, rdata/rresp forwarded, rid = latched id, rlast = (count==len). On handshake: last → R_IDLE, else count+1, advance address, → R_ADDR.
- Write FSM W_IDLE → W_DATA → W_ISSUE → W_RESP → (W_DATA | W_B). s_axi_awready = (state==W_IDLE).
- W_DATA: s_axi_wready=1; on handshake register wdata/wstrb, → W_ISSUE.
- W_ISSUE: m_axi_awvalid and m_axi_wvalid both asserted in the same cycle (peripherals require both); each drops independently after its own handshake; when both done → W_RESP.
- W_RESP: m_axi_bready=1; on m_axi_bvalid merge resp (keep numerically larger of accumulated and new). Last beat → W_B, else advance address → W_DATA.
- W_B: s_axi_bvalid=1, bid = latched id, bresp = accumulated; on s_axi_bready → W_IDLE, accumulator cleared to OKAY.
- Beat count governed by AxLEN only; s_axi_wlast ignored.
- Address advance: FIXED (0) holds; INCR (1) adds 1<<size, 32-bit wrap-around; WRAP (2) per Configuration; reserved (3) treated as INCR. 4 KB crossing not checked.
- m_axi_*prot = latched prot. Lite side carries no size; full 32-bit wdata/wstrb passed unmodified.

## Timing
- Reset (async assert, sync deassert use): both FSMs idle; all out valids 0; m_axi_bready=0; s_axi_wready=0; s_axi_arready=s_axi_awready=1; bresp accumulator OKAY.
- AR accepted cycle N → m_axi_arvalid cycle N+1. With always-ready slave returning R at N+2, s_axi_rvalid same cycle N+2 (zero added read latency); next beat AR at N+3.
- Write beat: W accept N → Lite AW/W at N+1 → slave B seen N+2 → next wready N+3.
- Reset mid-burst abandons burst immediately; no partial response issued.
- Read and write paths may be busy simultaneously; no ordering between them.

## Configuration
- BURST_WRAP_EN defined: WRAP bursts wrap at boundary (len+1)<<size (len ∈ {1,3,7,15}); address = (base & ~(boundary-1)) | ((addr + (1<<size)) & (boundary-1)).
- Undefined: WRAP treated as INCR; no wrap logic synthesised.

## Test plan
- After reset, AR addr 0x1faf_f000 len 0 id 5 to seven-segment controller → one Lite read, s_axi_rdata 0x01234567, rresp 0, rid 5, rlast 1.
- INCR write len 3 size 2 addr 0x100 id 2 → Lite AW addrs 0x100,0x104,0x108,0x10C each with AW/W valid together; single B, bid 2, bresp 0.
- FIXED read len 2 addr 0x40 → three Lite ARs all 0x40; rlast only on third beat; s_axi_rready held low 5 cycles stalls without data loss.
- 4-beat write, slave returns bresp 2 on beat 2, 0 elsewhere → s_axi_bresp 2, exactly one B after beat 4.
- WRAP read len 3 size 2 addr 0x0C → with BURST_WRAP_EN: 0x0C,0x00,0x04,0x08; without: 0x0C,0x10,0x14,0x18.
- aresetn low during beat 2 of 4 write → all valids 0 same cycle; after release awready=1, new burst completes normally.
